// File: rtl/sram_arbiter.sv
// Shared base-SRAM arbiter: MEM has strict priority over IF, one FSM sequences
// multi-cycle reads and writes, and every SRAM strobe, ack and read-data output is registered.
module sram_arbiter #(
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_AW     = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [31:0]        if_addr,
   output logic [31:0]        if_rdata,
   output logic               if_ack,
   input  logic               mem_req,
   input  logic               mem_we,
   input  logic [3:0]         mem_be,
   input  logic [31:0]        mem_addr,
   input  logic [31:0]        mem_wdata,
   output logic [31:0]        mem_rdata,
   output logic               mem_ack,
   output logic               stall_if,
   output logic               stall_mem,
   output logic               busy,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_wdata,
   input  logic [31:0]        sram_rdata,
   output logic               sram_data_oe,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic [3:0]         sram_be_n
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RECOVER = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               we_q, we_d;
   logic               gnt_mem_q, gnt_mem_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic               ce_n_q, ce_n_d;
   logic               oe_n_q, oe_n_d;
   logic               we_n_q, we_n_d;
   logic [3:0]         be_n_q, be_n_d;
   logic               data_oe_q, data_oe_d;
   logic               if_ack_q, if_ack_d;
   logic               mem_ack_q, mem_ack_d;
   logic [31:0]        if_rdata_q, if_rdata_d;
   logic [31:0]        mem_rdata_q, mem_rdata_d;

   // Grant selection: MEM wins whenever it is requesting, IF is always a read.
   logic        gnt_mem;
   logic        gnt_we;
   logic [31:0] gnt_addr;
   logic        unused_addr_bits;

   assign gnt_mem  = mem_req;
   assign gnt_we   = mem_req & mem_we;
   assign gnt_addr = mem_req ? mem_addr : if_addr;
   assign unused_addr_bits = ^{if_addr, mem_addr};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      gnt_mem_d   = gnt_mem_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ce_n_d      = ce_n_q;
      oe_n_d      = oe_n_q;
      we_n_d      = we_n_q;
      be_n_d      = be_n_q;
      data_oe_d   = data_oe_q;
      if_ack_d    = 1'b0;
      mem_ack_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;

      case (state_q)
         IDLE: begin
            if (mem_req || if_req) begin
               state_d   = ACCESS;
               cnt_d     = CNT_INIT;
               gnt_mem_d = gnt_mem;
               we_d      = gnt_we;
               addr_d    = gnt_addr[SRAM_AW+1:2];
               ce_n_d    = 1'b0;
               if (gnt_we) begin
                  oe_n_d    = 1'b1;
                  we_n_d    = 1'b0;
                  be_n_d    = ~mem_be;
                  data_oe_d = 1'b1;
                  wdata_d   = mem_wdata;
               end else begin
                  oe_n_d    = 1'b0;
                  we_n_d    = 1'b1;
                  be_n_d    = 4'h0;
                  data_oe_d = 1'b0;
               end
            end
         end

         ACCESS: begin
            if (cnt_q == '0) begin
               if (we_q) begin
                  // Release WE but keep CE, address, data and byte lanes driven for hold time.
                  state_d = RECOVER;
                  we_n_d  = 1'b1;
               end else begin
                  state_d   = DONE;
                  ce_n_d    = 1'b1;
                  oe_n_d    = 1'b1;
                  be_n_d    = 4'hF;
                  data_oe_d = 1'b0;
                  if (gnt_mem_q) begin
                     mem_rdata_d = sram_rdata;
                     mem_ack_d   = 1'b1;
                  end else begin
                     if_rdata_d = sram_rdata;
                     if_ack_d   = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         RECOVER: begin
            state_d   = DONE;
            ce_n_d    = 1'b1;
            oe_n_d    = 1'b1;
            we_n_d    = 1'b1;
            be_n_d    = 4'hF;
            data_oe_d = 1'b0;
            mem_ack_d = gnt_mem_q;
            if_ack_d  = ~gnt_mem_q;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         gnt_mem_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ce_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         be_n_q      <= 4'hF;
         data_oe_q   <= 1'b0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         gnt_mem_q   <= gnt_mem_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ce_n_q      <= ce_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         be_n_q      <= be_n_d;
         data_oe_q   <= data_oe_d;
         if_ack_q    <= if_ack_d;
         mem_ack_q   <= mem_ack_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign if_rdata     = if_rdata_q;
   assign if_ack       = if_ack_q;
   assign mem_rdata    = mem_rdata_q;
   assign mem_ack      = mem_ack_q;
   assign busy         = (state_q != IDLE);
   assign sram_addr    = addr_q;
   assign sram_wdata   = wdata_q;
   assign sram_data_oe = data_oe_q;
   assign sram_ce_n    = ce_n_q;
   assign sram_oe_n    = oe_n_q;
   assign sram_we_n    = we_n_q;
   assign sram_be_n    = be_n_q;

   // Stalls are combinational so the pipeline releases in the same cycle the ack arrives.
   assign stall_if  = if_req & ~if_ack_q;
   assign stall_mem = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, IF read, byte write, priority, late MEM request,
// empty-byte-enable write and an asynchronous reset in the middle of a write.
module tb_sram_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall_if;
   logic        stall_mem;
   logic        busy;
   logic [19:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_data_oe;
   logic        sram_ce_n;
   logic        sram_oe_n;
   logic        sram_we_n;
   logic [3:0]  sram_be_n;
   logic [7:0]  strb;

   int checks = 0;
   int errors = 0;

   sram_arbiter #(.WAIT_CYCLES(2), .SRAM_AW(20)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_rdata     (if_rdata),
      .if_ack       (if_ack),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_be       (mem_be),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .stall_if     (stall_if),
      .stall_mem    (stall_mem),
      .busy         (busy),
      .sram_addr    (sram_addr),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata),
      .sram_data_oe (sram_data_oe),
      .sram_ce_n    (sram_ce_n),
      .sram_oe_n    (sram_oe_n),
      .sram_we_n    (sram_we_n),
      .sram_be_n    (sram_be_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: word 0x00004 holds 0xDEADBEEF, every other word returns A5A concatenated with its address.
   always_comb sram_rdata = (sram_addr == 20'h00004) ? 32'hDEADBEEF : {12'hA5A, sram_addr};

   // {ce_n, oe_n, we_n, be_n[3:0], data_oe}
   assign strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_data_oe};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
      mem_be = 4'h0; mem_addr = '0; mem_wdata = '0;
      repeat (3) @(posedge clk);
      mid();
      checks++; if (strb !== 8'hFE) begin errors++; $display("FAIL rst_strobes: got %h expected fe", strb); end
      checks++; if ({sram_addr, sram_wdata} !== 52'h0) begin errors++; $display("FAIL rst_addr_wdata: got %h %h expected 0 0", sram_addr, sram_wdata); end
      checks++; if ({if_ack, mem_ack, busy, stall_if, stall_mem} !== 5'b0) begin errors++; $display("FAIL rst_ctrl: got %b expected 00000", {if_ack, mem_ack, busy, stall_if, stall_mem}); end
      checks++; if ({if_rdata, mem_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h %h expected 0 0", if_rdata, mem_rdata); end
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_if_read();
      if_req = 1'b1; if_addr = 32'h80000010;
      mid();
      checks++; if ({stall_if, busy} !== 2'b10) begin errors++; $display("FAIL ifrd_c0: got stall/busy %b expected 10", {stall_if, busy}); end
      for (int c = 1; c <= 2; c++) begin
         step(); mid();
         checks++; if (sram_addr !== 20'h00004) begin errors++; $display("FAIL ifrd_addr_c%0d: got %h expected 00004", c, sram_addr); end
         checks++; if (strb !== 8'h20) begin errors++; $display("FAIL ifrd_strb_c%0d: got %h expected 20", c, strb); end
         checks++; if ({stall_if, if_ack, busy} !== 3'b101) begin errors++; $display("FAIL ifrd_ctrl_c%0d: got %b expected 101", c, {stall_if, if_ack, busy}); end
      end
      step(); mid();
      checks++; if ({if_ack, stall_if, mem_ack} !== 3'b100) begin errors++; $display("FAIL ifrd_ack_c3: got %b expected 100", {if_ack, stall_if, mem_ack}); end
      checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ifrd_data: got %h expected deadbeef", if_rdata); end
      checks++; if (strb !== 8'hFE) begin errors++; $display("FAIL ifrd_strb_c3: got %h expected fe", strb); end
      step(); if_req = 1'b0; mid();
      checks++; if ({if_ack, busy} !== 2'b00) begin errors++; $display("FAIL ifrd_c4: got ack/busy %b expected 00", {if_ack, busy}); end
      checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ifrd_hold: got %h expected deadbeef", if_rdata); end
      step();
   endtask

   task automatic test_byte_write();
      mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0010; mem_addr = 32'h80000102; mem_wdata = 32'h0000AB00;
      mid();
      checks++; if (stall_mem !== 1'b1) begin errors++; $display("FAIL wr_stall_c0: got %b expected 1", stall_mem); end
      for (int c = 1; c <= 2; c++) begin
         step(); mid();
         checks++; if (sram_addr !== 20'h00040) begin errors++; $display("FAIL wr_addr_c%0d: got %h expected 00040", c, sram_addr); end
         checks++; if (strb !== 8'h5B) begin errors++; $display("FAIL wr_strb_c%0d: got %h expected 5b", c, strb); end
         checks++; if (sram_wdata !== 32'h0000AB00) begin errors++; $display("FAIL wr_wdata_c%0d: got %h expected 0000ab00", c, sram_wdata); end
      end
      step(); mid();
      checks++; if (strb !== 8'h7B) begin errors++; $display("FAIL wr_recover_strb: got %h expected 7b", strb); end
      checks++; if ({mem_ack, stall_mem, sram_addr} !== {2'b01, 20'h00040}) begin errors++; $display("FAIL wr_recover_ctrl: got %b %h expected 01 00040", {mem_ack, stall_mem}, sram_addr); end
      step(); mid();
      checks++; if ({mem_ack, stall_mem, if_ack} !== 3'b100) begin errors++; $display("FAIL wr_ack_c4: got %b expected 100", {mem_ack, stall_mem, if_ack}); end
      checks++; if (strb !== 8'hFE) begin errors++; $display("FAIL wr_done_strb: got %h expected fe", strb); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata_kept: got %h expected 0", mem_rdata); end
      step(); mem_req = 1'b0; mem_we = 1'b0; mid();
      checks++; if ({mem_ack, busy} !== 2'b00) begin errors++; $display("FAIL wr_c5: got ack/busy %b expected 00", {mem_ack, busy}); end
      step();
   endtask

   task automatic test_priority();
      if_req = 1'b1; if_addr = 32'h00000304;
      mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hA; mem_addr = 32'h00000200;
      step(); mid();
      checks++; if ({sram_addr, strb} !== {20'h00080, 8'h20}) begin errors++; $display("FAIL pri_mem_first: got %h %h expected 00080 20", sram_addr, strb); end
      step(); step(); mid();
      checks++; if ({mem_ack, if_ack, stall_if} !== 3'b101) begin errors++; $display("FAIL pri_mem_ack_c3: got %b expected 101", {mem_ack, if_ack, stall_if}); end
      checks++; if ({mem_rdata, if_rdata} !== {32'hA5A00080, 32'hDEADBEEF}) begin errors++; $display("FAIL pri_mem_data: got %h %h expected a5a00080 deadbeef", mem_rdata, if_rdata); end
      step(); mem_req = 1'b0; mid();
      checks++; if ({busy, stall_if} !== 2'b01) begin errors++; $display("FAIL pri_idle_c4: got busy/stall %b expected 01", {busy, stall_if}); end
      step(); mid();
      checks++; if ({sram_addr, strb} !== {20'h000C1, 8'h20}) begin errors++; $display("FAIL pri_if_access_c5: got %h %h expected 000c1 20", sram_addr, strb); end
      step(); mid();
      checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL pri_if_early_c6: got %b expected 0", if_ack); end
      step(); mid();
      checks++; if ({if_ack, mem_ack} !== 2'b10) begin errors++; $display("FAIL pri_if_ack_c7: got %b expected 10", {if_ack, mem_ack}); end
      checks++; if ({if_rdata, mem_rdata} !== {32'hA5A000C1, 32'hA5A00080}) begin errors++; $display("FAIL pri_if_data: got %h %h expected a5a000c1 a5a00080", if_rdata, mem_rdata); end
      step(); if_req = 1'b0; step();
   endtask

   task automatic test_late_mem();
      if_req = 1'b1; if_addr = 32'h80000010;
      step();
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h00000204;
      mid();
      checks++; if ({sram_addr, strb} !== {20'h00004, 8'h20}) begin errors++; $display("FAIL late_if_kept_c1: got %h %h expected 00004 20", sram_addr, strb); end
      step(); step(); mid();
      checks++; if ({if_ack, mem_ack, stall_mem} !== 3'b101) begin errors++; $display("FAIL late_if_ack_c3: got %b expected 101", {if_ack, mem_ack, stall_mem}); end
      checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL late_if_data: got %h expected deadbeef", if_rdata); end
      step(); if_req = 1'b0; mid();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL late_idle_c4: got busy %b expected 0", busy); end
      step(); mid();
      checks++; if ({busy, sram_addr} !== {1'b1, 20'h00081}) begin errors++; $display("FAIL late_mem_grant_c5: got %b %h expected 1 00081", busy, sram_addr); end
      step(); mid();
      checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL late_mem_early_c6: got %b expected 0", mem_ack); end
      step(); mid();
      checks++; if ({mem_ack, mem_rdata} !== {1'b1, 32'hA5A00081}) begin errors++; $display("FAIL late_mem_ack_c7: got %b %h expected 1 a5a00081", mem_ack, mem_rdata); end
      step(); mem_req = 1'b0; step();
   endtask

   task automatic test_be_zero();
      mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'h0; mem_addr = 32'h80000020; mem_wdata = 32'hCAFEF00D;
      step(); mid();
      checks++; if ({sram_addr, strb} !== {20'h00008, 8'h5F}) begin errors++; $display("FAIL be0_access: got %h %h expected 00008 5f", sram_addr, strb); end
      step(); step(); mid();
      checks++; if ({strb, mem_ack} !== {8'h7F, 1'b0}) begin errors++; $display("FAIL be0_recover: got %h %b expected 7f 0", strb, mem_ack); end
      step(); mid();
      checks++; if ({mem_ack, mem_rdata} !== {1'b1, 32'hA5A00081}) begin errors++; $display("FAIL be0_ack: got %b %h expected 1 a5a00081", mem_ack, mem_rdata); end
      step(); mem_req = 1'b0; mem_we = 1'b0; step();
   endtask

   task automatic test_reset_midwrite();
      mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'hF; mem_addr = 32'h00000008; mem_wdata = 32'h12345678;
      step(); mid();
      checks++; if ({strb, sram_wdata} !== {8'h41, 32'h12345678}) begin errors++; $display("FAIL rmw_access: got %h %h expected 41 12345678", strb, sram_wdata); end
      #2 rst = 1'b0;
      #1;
      checks++; if (strb !== 8'hFE) begin errors++; $display("FAIL rmw_async_strb: got %h expected fe", strb); end
      checks++; if ({busy, sram_addr, sram_wdata} !== 53'h0) begin errors++; $display("FAIL rmw_async_regs: got %b %h %h expected 0 0 0", busy, sram_addr, sram_wdata); end
      step(); mem_req = 1'b0; mem_we = 1'b0; mid();
      checks++; if ({mem_ack, busy} !== 2'b00) begin errors++; $display("FAIL rmw_in_reset: got %b expected 00", {mem_ack, busy}); end
      step(); rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         mid();
         checks++; if ({mem_ack, if_ack, busy, strb} !== {3'b000, 8'hFE}) begin errors++; $display("FAIL rmw_quiet_%0d: got %b %h expected 000 fe", c, {mem_ack, if_ack, busy}, strb); end
         step();
      end
      if_req = 1'b1; if_addr = 32'h00000304;
      step(); step(); step(); mid();
      checks++; if ({if_ack, if_rdata} !== {1'b1, 32'hA5A000C1}) begin errors++; $display("FAIL rmw_restart_ack: got %b %h expected 1 a5a000c1", if_ack, if_rdata); end
      step(); if_req = 1'b0; step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_if_read();
      test_byte_write();
      test_priority();
      test_late_mem();
      test_be_zero();
      test_reset_midwrite();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
